triangle_dispatcher: RTL and testbench

//  Sequences triangle setup: walks an index buffer, fetches three vertices per triangle

---
 rtl/triangle_dispatcher_if.sv | 33 +++
 rtl/triangle_dispatcher.sv | 202 ++++++++++++++++++++
 tb/tb_triangle_dispatcher.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/triangle_dispatcher_if.sv
// Dispatcher memory and front-end bundle.
// Ports grouped here:
//   idx_addr/idx_data    index-buffer read port. idx_data = {i2,i1,i0}, valid one cycle after the address.
//   vtx_addr/vtx_data    vertex-memory read port. vtx_data = {z,y,x}, valid one cycle after the address.
//   fe_ready             the rasterizer front end is idle and accepting.
//   fe_v0/fe_v1/fe_v2    triangle vertices. Element [0]=x, [1]=y, [2]=z.
//   fe_triangle_dv       one-cycle triangle-valid pulse.
// master = dispatcher side, slave = memory/front-end side.
interface triangle_dispatcher_if #(
    parameter int unsigned DATAWIDTH = 12,
    parameter int unsigned IDX_AW    = 10,
    parameter int unsigned VTX_AW    = 10
);
    logic [IDX_AW-1:0]               idx_addr;
    logic [3*VTX_AW-1:0]             idx_data;
    logic [VTX_AW-1:0]               vtx_addr;
    logic [3*DATAWIDTH-1:0]          vtx_data;
    logic                            fe_ready;
    logic [2:0][DATAWIDTH-1:0]       fe_v0;
    logic [2:0][DATAWIDTH-1:0]       fe_v1;
    logic [2:0][DATAWIDTH-1:0]       fe_v2;
    logic                            fe_triangle_dv;

    modport master (
        output idx_addr, vtx_addr, fe_v0, fe_v1, fe_v2, fe_triangle_dv,
        input  idx_data, vtx_data, fe_ready
    );

    modport slave (
        input  idx_addr, vtx_addr, fe_v0, fe_v1, fe_v2, fe_triangle_dv,
        output idx_data, vtx_data, fe_ready
    );
endinterface

// File: rtl/triangle_dispatcher.sv
// triangle_dispatcher: walks an index buffer, fetches three vertices per triangle
// and hands each triangle to the rasterizer front end. There is one start/done
// handshake per draw call.
// Ports:
//   clk, rstn (synchronous, active-low)
//   start, num_triangles, num_vertices   draw-call request. Sampled when idle.
//   busy, done, err_index, tri_issued    draw status.
//   stall_cycles                         count of WAIT_FE cycles with fe_ready low.
//   bus (triangle_dispatcher_if.master)  memory read ports and front-end handshake.
// Optional feature: define DISPATCH_PERF_EN to build the stall counter.
// Without it, stall_cycles is tied to zero.
module triangle_dispatcher #(
    parameter int unsigned DATAWIDTH = 12,
    parameter int unsigned IDX_AW    = 10,
    parameter int unsigned VTX_AW    = 10
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   start,
    input  logic [IDX_AW-1:0]      num_triangles,
    input  logic [VTX_AW-1:0]      num_vertices,
    output logic                   busy,
    output logic                   done,
    output logic                   err_index,
    output logic [IDX_AW-1:0]      tri_issued,
    output logic [15:0]            stall_cycles,
    triangle_dispatcher_if.master  bus
);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH_IDX, S_IDX_RDY, S_VA0, S_VA1, S_VA2,
        S_VCAP, S_WAIT_FE, S_SEND, S_GUARD, S_DONE
    } state_t;

    state_t                    state_q, state_d;
    logic [IDX_AW-1:0]         nt_q, nt_d;
    logic [VTX_AW-1:0]         nv_q, nv_d;
    logic [IDX_AW-1:0]         tri_ptr_q, tri_ptr_d;
    logic [IDX_AW-1:0]         tri_issued_q, tri_issued_d;
    logic                      err_q, err_d;
    logic [VTX_AW-1:0]         idx1_q, idx1_d, idx2_q, idx2_d;
    logic [IDX_AW-1:0]         idx_addr_q, idx_addr_d;
    logic [VTX_AW-1:0]         vtx_addr_q, vtx_addr_d;
    logic [2:0][DATAWIDTH-1:0] v0_q, v0_d, v1_q, v1_d, v2_q, v2_d;
    logic                      busy_q, busy_d, done_q, done_d, dv_q, dv_d;
    logic [2:0][VTX_AW-1:0]    idx_in;
    logic                      idx_bad;

    assign idx_in  = bus.idx_data;
    assign idx_bad = (idx_in[0] >= nv_q) || (idx_in[1] >= nv_q) || (idx_in[2] >= nv_q);

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= S_IDLE;
            nt_q         <= '0;
            nv_q         <= '0;
            tri_ptr_q    <= '0;
            tri_issued_q <= '0;
            err_q        <= 1'b0;
            idx1_q       <= '0;
            idx2_q       <= '0;
            idx_addr_q   <= '0;
            vtx_addr_q   <= '0;
            v0_q         <= '0;
            v1_q         <= '0;
            v2_q         <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            dv_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            nt_q         <= nt_d;
            nv_q         <= nv_d;
            tri_ptr_q    <= tri_ptr_d;
            tri_issued_q <= tri_issued_d;
            err_q        <= err_d;
            idx1_q       <= idx1_d;
            idx2_q       <= idx2_d;
            idx_addr_q   <= idx_addr_d;
            vtx_addr_q   <= vtx_addr_d;
            v0_q         <= v0_d;
            v1_q         <= v1_d;
            v2_q         <= v2_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            dv_q         <= dv_d;
        end
    end

    // Next state and next register values
    always_comb begin
        state_d      = state_q;
        nt_d         = nt_q;
        nv_d         = nv_q;
        tri_ptr_d    = tri_ptr_q;
        tri_issued_d = tri_issued_q;
        err_d        = err_q;
        idx1_d       = idx1_q;
        idx2_d       = idx2_q;
        idx_addr_d   = idx_addr_q;
        vtx_addr_d   = vtx_addr_q;
        v0_d         = v0_q;
        v1_d         = v1_q;
        v2_d         = v2_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    nt_d         = num_triangles;
                    nv_d         = num_vertices;
                    tri_ptr_d    = '0;
                    tri_issued_d = '0;
                    err_d        = 1'b0;
                    // An empty draw passes through the GUARD dead cycle, so its
                    // done pulse lands two cycles after start.
                    state_d      = (num_triangles == '0) ? S_GUARD : S_FETCH_IDX;
                end
            end
            S_FETCH_IDX: state_d = S_IDX_RDY;
            S_IDX_RDY: begin
                idx1_d = idx_in[1];
                idx2_d = idx_in[2];
                if (idx_bad) begin
                    err_d     = 1'b1;
                    tri_ptr_d = tri_ptr_q + IDX_AW'(1);
                    state_d   = S_GUARD;
                end else begin
                    vtx_addr_d = idx_in[0];
                    state_d    = S_VA0;
                end
            end
            S_VA0: begin
                vtx_addr_d = idx1_q;
                state_d    = S_VA1;
            end
            S_VA1: begin
                vtx_addr_d = idx2_q;
                v0_d       = bus.vtx_data;
                state_d    = S_VA2;
            end
            S_VA2: begin
                v1_d    = bus.vtx_data;
                state_d = S_VCAP;
            end
            S_VCAP: begin
                v2_d    = bus.vtx_data;
                state_d = S_WAIT_FE;
            end
            S_WAIT_FE: if (bus.fe_ready) state_d = S_SEND;
            S_SEND: begin
                tri_issued_d = tri_issued_q + IDX_AW'(1);
                tri_ptr_d    = tri_ptr_q + IDX_AW'(1);
                state_d      = S_GUARD;
            end
            S_GUARD: state_d = (tri_ptr_q == nt_q) ? S_DONE : S_FETCH_IDX;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // The index address must be valid during the FETCH_IDX cycle itself.
        if (state_d == S_FETCH_IDX) idx_addr_d = tri_ptr_d;

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
        dv_d   = (state_d == S_SEND);
    end

`ifdef DISPATCH_PERF_EN
    logic [15:0] stall_q, stall_d;

    // Saturating count of front-end back-pressure cycles
    always_comb begin
        stall_d = stall_q;
        if (state_q == S_IDLE && start)
            stall_d = '0;
        else if (state_q == S_WAIT_FE && !bus.fe_ready && stall_q != 16'hFFFF)
            stall_d = stall_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!rstn) stall_q <= '0;
        else       stall_q <= stall_d;
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = 16'h0000;
`endif

    assign busy               = busy_q;
    assign done               = done_q;
    assign err_index          = err_q;
    assign tri_issued         = tri_issued_q;
    assign bus.idx_addr       = idx_addr_q;
    assign bus.vtx_addr       = vtx_addr_q;
    assign bus.fe_v0          = v0_q;
    assign bus.fe_v1          = v1_q;
    assign bus.fe_v2          = v2_q;
    assign bus.fe_triangle_dv = dv_q;

endmodule

// File: tb/tb_triangle_dispatcher.sv
// Self-checking bench for triangle_dispatcher.
// The memories are behavioural. Expected triangles, timing and flags come from a
// per-draw model built out of the index and vertex tables.
module tb_triangle_dispatcher;
    localparam int unsigned DW  = 12;
    localparam int unsigned IAW = 10;
    localparam int unsigned VAW = 10;
`ifdef DISPATCH_PERF_EN
    localparam int EXP_STALL = 20;
`else
    localparam int EXP_STALL = 0;
`endif

    logic clk = 1'b0;
    logic rstn, start;
    logic [IAW-1:0] num_triangles;
    logic [VAW-1:0] num_vertices;
    logic busy, done, err_index;
    logic [IAW-1:0] tri_issued;
    logic [15:0] stall_cycles;

    triangle_dispatcher_if #(.DATAWIDTH(DW), .IDX_AW(IAW), .VTX_AW(VAW)) bus ();

    triangle_dispatcher #(.DATAWIDTH(DW), .IDX_AW(IAW), .VTX_AW(VAW)) dut (
        .clk(clk), .rstn(rstn), .start(start),
        .num_triangles(num_triangles), .num_vertices(num_vertices),
        .busy(busy), .done(done), .err_index(err_index),
        .tri_issued(tri_issued), .stall_cycles(stall_cycles),
        .bus(bus.master)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int ix0 [1024], ix1 [1024], ix2 [1024];
    int vx [1024], vy [1024], vz [1024];

    // Synchronous-read memories
    always @(posedge clk) begin
        bus.idx_data <= {VAW'(ix2[bus.idx_addr]), VAW'(ix1[bus.idx_addr]), VAW'(ix0[bus.idx_addr])};
        bus.vtx_data <= {DW'(vz[bus.vtx_addr]), DW'(vy[bus.vtx_addr]), DW'(vx[bus.vtx_addr])};
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor. It samples on the falling edge.
    int dv_n[$];
    int done_n[$];
    logic [3*DW-1:0] q_v0[$], q_v1[$], q_v2[$];
    always @(negedge clk) begin
        if (bus.fe_triangle_dv === 1'b1) begin
            dv_n.push_back(cyc);
            q_v0.push_back(bus.fe_v0);
            q_v1.push_back(bus.fe_v1);
            q_v2.push_back(bus.fe_v2);
        end
        if (done === 1'b1) done_n.push_back(cyc);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_mon();
        dv_n.delete(); done_n.delete();
        q_v0.delete(); q_v1.delete(); q_v2.delete();
    endtask

    function automatic logic [3*DW-1:0] vert(input int i);
        return {DW'(vz[i]), DW'(vy[i]), DW'(vx[i])};
    endfunction

    // Random draw content. Each triangle is corrupted with probability bad_pct%.
    task automatic fill(input int nt, input int nv, input int bad_pct);
        for (int i = 0; i < 1024; i++) begin
            vx[i] = int'($urandom_range(0, 4095));
            vy[i] = int'($urandom_range(0, 4095));
            vz[i] = int'($urandom_range(0, 4095));
        end
        for (int t = 0; t < nt; t++) begin
            ix0[t] = int'($urandom_range(0, nv - 1));
            ix1[t] = int'($urandom_range(0, nv - 1));
            ix2[t] = int'($urandom_range(0, nv - 1));
            if (int'($urandom_range(0, 99)) < bad_pct) begin
                case ($urandom_range(0, 2))
                    0: ix0[t] = int'($urandom_range(nv, 1023));
                    1: ix1[t] = int'($urandom_range(nv, 1023));
                    default: ix2[t] = int'($urandom_range(nv, 1023));
                endcase
            end
        end
    endtask

    // Runs one draw and compares it against the model.
    // With rand_ready=0, fe_ready is held high and timing is checked exactly.
    task automatic run_draw(input string name, input int nt, input int nv, input bit rand_ready);
        int s, off, budget, n, done_exp;
        bit exp_err;
        int exp_n[$];
        logic [3*DW-1:0] e0[$], e1[$], e2[$];
        off = 0; exp_err = 1'b0;
        for (int t = 0; t < nt; t++) begin
            if (ix0[t] < nv && ix1[t] < nv && ix2[t] < nv) begin
                exp_n.push_back(8 + off);
                e0.push_back(vert(ix0[t])); e1.push_back(vert(ix1[t])); e2.push_back(vert(ix2[t]));
                off += 9;
            end else begin
                exp_err = 1'b1;
                off += 3;
            end
        end
        done_exp = ((nt == 0) ? 1 : off) + 1;

        clear_mon();
        bus.fe_ready  = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        num_triangles = IAW'(nt);
        num_vertices  = VAW'(nv);
        start = 1'b1;
        s = cyc;
        tick();
        start = 1'b0;
        num_triangles = IAW'($urandom);
        num_vertices  = VAW'($urandom);
        total++;
        if (busy !== 1'b1) begin
            bad++; $display("FAIL %s busy_after_start got=%b want=1", name, busy);
        end
        budget = 50 + nt * 120;
        n = 0;
        while (done_n.size() == 0 && n < budget) begin
            if (rand_ready) bus.fe_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        bus.fe_ready = 1'b1;
        total++;
        if (done_n.size() == 0) begin
            bad++; $display("FAIL %s done_timeout got=none want=done within %0d cycles", name, budget);
        end
        tick();
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || done_n.size() != 1) begin
            bad++; $display("FAIL %s end_handshake got busy=%b done=%b pulses=%0d want busy=0 done=0 pulses=1",
                            name, busy, done, done_n.size());
        end
        total++;
        if (dv_n.size() != exp_n.size()) begin
            bad++; $display("FAIL %s dv_count got=%0d want=%0d", name, dv_n.size(), exp_n.size());
        end
        for (int k = 0; k < exp_n.size() && k < dv_n.size(); k++) begin
            total++;
            if (q_v0[k] !== e0[k] || q_v1[k] !== e1[k] || q_v2[k] !== e2[k]) begin
                bad++; $display("FAIL %s tri%0d_vertices got=%h/%h/%h want=%h/%h/%h",
                                name, k, q_v0[k], q_v1[k], q_v2[k], e0[k], e1[k], e2[k]);
            end
            if (!rand_ready) begin
                total++;
                if (dv_n[k] - s !== exp_n[k]) begin
                    bad++; $display("FAIL %s tri%0d_dv_time got=T+%0d want=T+%0d", name, k, dv_n[k] - s, exp_n[k]);
                end
            end
        end
        if (!rand_ready && done_n.size() > 0) begin
            total++;
            if (done_n[0] - s !== done_exp) begin
                bad++; $display("FAIL %s done_time got=T+%0d want=T+%0d", name, done_n[0] - s, done_exp);
            end
        end
        total++;
        if (tri_issued !== IAW'(exp_n.size())) begin
            bad++; $display("FAIL %s tri_issued got=%0d want=%0d", name, tri_issued, exp_n.size());
        end
        total++;
        if (err_index !== exp_err) begin
            bad++; $display("FAIL %s err_index got=%b want=%b", name, err_index, exp_err);
        end
        if (!rand_ready) begin
            total++;
            if (stall_cycles !== 16'd0) begin
                bad++; $display("FAIL %s stall_no_backpressure got=%0d want=0", name, stall_cycles);
            end
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0; start = 1'b0; bus.fe_ready = 1'b0;
        num_triangles = '0; num_vertices = '0;
        tick(); tick();
        total++;
        if ({busy, done, err_index, bus.fe_triangle_dv} !== 4'b0) begin
            bad++; $display("FAIL reset_flags got=%b want=0000", {busy, done, err_index, bus.fe_triangle_dv});
        end
        total++;
        if (tri_issued !== '0 || stall_cycles !== '0 || bus.idx_addr !== '0 || bus.vtx_addr !== '0) begin
            bad++; $display("FAIL reset_counts got=%0d/%0d/%0d/%0d want=0/0/0/0",
                            tri_issued, stall_cycles, bus.idx_addr, bus.vtx_addr);
        end
        total++;
        if (bus.fe_v0 !== '0 || bus.fe_v1 !== '0 || bus.fe_v2 !== '0) begin
            bad++; $display("FAIL reset_vertices got=%h/%h/%h want=0", bus.fe_v0, bus.fe_v1, bus.fe_v2);
        end
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_single();
        fill(1, 3, 0);
        ix0[0] = 0; ix1[0] = 1; ix2[0] = 2;
        run_draw("single", 1, 3, 1'b0);
    endtask

    task automatic test_back_to_back();
        fill(3, 50, 0);
        run_draw("three", 3, 50, 1'b0);
        fill(0, 1, 0);
        run_draw("zero", 0, 1, 1'b0);
    endtask

    task automatic test_bad_index();
        fill(2, 4, 0);
        ix0[0] = 0; ix1[0] = 1; ix2[0] = 2;
        ix0[1] = 0; ix1[1] = 1; ix2[1] = 7;
        run_draw("bad_index", 2, 4, 1'b0);
    endtask

    task automatic test_random();
        for (int r = 0; r < 8; r++) begin
            int nt, nv;
            nt = int'($urandom_range(1, 6));
            nv = int'($urandom_range(1, 1023));
            fill(nt, nv, 25);
            run_draw($sformatf("rand%0d", r), nt, nv, r[0]);
        end
    endtask

    // Front end stalls for 20 WAIT_FE cycles. A second start mid-draw must be ignored.
    task automatic test_stall();
        int s, n;
        fill(1, 10, 0);
        clear_mon();
        bus.fe_ready = 1'b0;
        num_triangles = IAW'(1); num_vertices = VAW'(10);
        start = 1'b1; s = cyc;
        tick();
        start = 1'b0;
        while (cyc < s + 5) tick();
        num_triangles = IAW'(5); num_vertices = VAW'(2);
        start = 1'b1;
        tick();
        start = 1'b0;
        while (cyc < s + 27) tick();
        bus.fe_ready = 1'b1;
        n = 0;
        while (done_n.size() == 0 && n < 100) begin tick(); n++; end
        tick();
        total++;
        if (dv_n.size() != 1 || (dv_n.size() == 1 && dv_n[0] - s != 28)) begin
            bad++; $display("FAIL stall_dv got=%0d pulses first=T+%0d want=1 pulse at T+28",
                            dv_n.size(), (dv_n.size() > 0) ? dv_n[0] - s : -1);
        end
        total++;
        if (q_v0.size() != 1 || (q_v0.size() == 1 && q_v0[0] !== vert(ix0[0]))) begin
            bad++; $display("FAIL stall_vertex got=%0d entries want v0=%h", q_v0.size(), vert(ix0[0]));
        end
        total++;
        if (stall_cycles !== 16'(EXP_STALL)) begin
            bad++; $display("FAIL stall_cycles got=%0d want=%0d", stall_cycles, EXP_STALL);
        end
        total++;
        if (done_n.size() != 1 || tri_issued !== IAW'(1) || err_index !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL stall_ignore_start got done=%0d issued=%0d err=%b busy=%b want 1/1/0/0",
                            done_n.size(), tri_issued, err_index, busy);
        end
    endtask

    task automatic test_reset_mid();
        int s, dv_before;
        fill(3, 100, 0);
        clear_mon();
        bus.fe_ready = 1'b1;
        num_triangles = IAW'(3); num_vertices = VAW'(100);
        start = 1'b1; s = cyc;
        tick();
        start = 1'b0;
        while (cyc < s + 12) tick();
        rstn = 1'b0;
        tick();
        total++;
        if ({busy, done, err_index, bus.fe_triangle_dv} !== 4'b0 || tri_issued !== '0 || stall_cycles !== '0) begin
            bad++; $display("FAIL reset_mid_flags got busy=%b done=%b err=%b dv=%b issued=%0d stall=%0d want all 0",
                            busy, done, err_index, bus.fe_triangle_dv, tri_issued, stall_cycles);
        end
        total++;
        if (bus.idx_addr !== '0 || bus.vtx_addr !== '0 || bus.fe_v0 !== '0) begin
            bad++; $display("FAIL reset_mid_bus got idx=%0d vtx=%0d v0=%h want 0/0/0",
                            bus.idx_addr, bus.vtx_addr, bus.fe_v0);
        end
        rstn = 1'b1;
        dv_before = dv_n.size();
        for (int i = 0; i < 40; i++) tick();
        total++;
        if (done_n.size() != 0 || dv_n.size() != dv_before || busy !== 1'b0) begin
            bad++; $display("FAIL reset_mid_abort got done=%0d dv=%0d busy=%b want done=0 dv=%0d busy=0",
                            done_n.size(), dv_n.size(), busy, dv_before);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            ix0[i] = 0; ix1[i] = 0; ix2[i] = 0; vx[i] = 0; vy[i] = 0; vz[i] = 0;
        end
        test_reset();
        test_single();
        test_back_to_back();
        test_bad_index();
        test_stall();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
